// File: rtl/fifo_arb_ctrl_if.sv
// fifo_arb_ctrl_if: requester, RAM and consumer signals of fifo_arb_ctrl.
// FIFO_ARB_ERR_EN adds the sticky error flags.
interface fifo_arb_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 16,
    parameter int DW    = 8
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(NREQ);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [GW-1:0]      grant_id;
    logic               busy;
    logic               ram_we;
    logic [AW-1:0]      ram_waddr;
    logic [DW-1:0]      ram_wdata;
    logic               rd_en;
    logic [AW-1:0]      ram_raddr;
    logic               full;
    logic               empty;
    logic [AW:0]        count;
    logic [AW:0]        wr_ptr_gray;
    logic [AW:0]        rd_ptr_gray;
`ifdef FIFO_ARB_ERR_EN
    logic               err_underflow;
    logic               err_protocol;
    modport master (output req_valid, req_data, rd_en,
                    input req_ready, grant_id, busy, ram_we, ram_waddr, ram_wdata, ram_raddr,
                          full, empty, count, wr_ptr_gray, rd_ptr_gray, err_underflow, err_protocol);
    modport slave  (input req_valid, req_data, rd_en,
                    output req_ready, grant_id, busy, ram_we, ram_waddr, ram_wdata, ram_raddr,
                           full, empty, count, wr_ptr_gray, rd_ptr_gray, err_underflow, err_protocol);
`else
    modport master (output req_valid, req_data, rd_en,
                    input req_ready, grant_id, busy, ram_we, ram_waddr, ram_wdata, ram_raddr,
                          full, empty, count, wr_ptr_gray, rd_ptr_gray);
    modport slave  (input req_valid, req_data, rd_en,
                    output req_ready, grant_id, busy, ram_we, ram_waddr, ram_wdata, ram_raddr,
                           full, empty, count, wr_ptr_gray, rd_ptr_gray);
`endif
endinterface

// File: rtl/fifo_arb_ctrl.sv
// fifo_arb_ctrl: round-robin burst arbiter sharing one FIFO write port, with pointer/status logic.
// Optional FIFO_ARB_ERR_EN adds sticky err_underflow and err_protocol flags.
module fifo_arb_ctrl #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 16,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input logic            clk,
    input logic            rst,
    fifo_arb_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int GW = $clog2(NREQ);
    localparam int BW = $clog2(BURST + 1);
    typedef enum logic {ARB, GRANT} state_t;
    state_t        state;
    logic [AW:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [GW-1:0] last_grant, next_id, idx;
    logic [BW-1:0] beats;
    logic          hit, push, pop, gvalid;

    assign gvalid         = bus.req_valid[bus.grant_id];
    assign bus.busy       = state == GRANT;
    assign bus.empty      = wr_ptr == rd_ptr;
    assign bus.full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign bus.count      = wr_ptr - rd_ptr;
    assign bus.req_ready  = (bus.busy && !bus.full) ? NREQ'(1) << bus.grant_id : '0;
    assign push           = bus.busy && gvalid && !bus.full;
    assign pop            = bus.rd_en && !bus.empty;
    assign bus.ram_we     = push;
    assign bus.ram_waddr  = wr_ptr[AW-1:0];
    assign bus.ram_wdata  = bus.req_data[bus.grant_id*DW +: DW];
    assign bus.ram_raddr  = rd_ptr[AW-1:0];
    assign wr_nxt         = wr_ptr + PW'(push);
    assign rd_nxt         = rd_ptr + PW'(pop);

    // first valid requester after the last grant, wrapping
    always_comb begin
        hit     = 1'b0;
        next_id = last_grant;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = GW'((int'(last_grant) + k) % NREQ);
            if (!hit && bus.req_valid[idx]) begin
                hit     = 1'b1;
                next_id = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= ARB;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            bus.wr_ptr_gray <= '0;
            bus.rd_ptr_gray <= '0;
            bus.grant_id    <= '0;
            last_grant      <= GW'(NREQ - 1);
            beats           <= '0;
        end else begin
            wr_ptr          <= wr_nxt;
            rd_ptr          <= rd_nxt;
            bus.wr_ptr_gray <= wr_nxt ^ (wr_nxt >> 1);
            bus.rd_ptr_gray <= rd_nxt ^ (rd_nxt >> 1);
            if (state == ARB) begin
                if (hit) begin
                    state        <= GRANT;
                    bus.grant_id <= next_id;
                    last_grant   <= next_id;
                end
            end else if (!gvalid || (push && beats == BW'(BURST - 1))) begin
                state <= ARB;
                beats <= '0;
            end else if (push) begin
                beats <= beats + 1'b1;
            end
        end
    end

`ifdef FIFO_ARB_ERR_EN
    // stall_q: granted requester held a word last cycle that full refused
    logic stall_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.err_underflow <= 1'b0;
            bus.err_protocol  <= 1'b0;
            stall_q           <= 1'b0;
        end else begin
            stall_q <= bus.busy && gvalid && bus.full;
            if (bus.rd_en && bus.empty) bus.err_underflow <= 1'b1;
            if (stall_q && bus.busy && bus.full && !gvalid) bus.err_protocol <= 1'b1;
        end
    end
`endif
endmodule

// File: doc/fifo_arb_ctrl.md
Name: fifo_arb_ctrl

Overview:
- Single-clock controller that shares one FIFO write port among NREQ requesters using round-robin burst arbitration.
- Owns the FIFO write/read pointers and drives an external dual-port RAM: write address/data/enable and read address.
- Publishes Gray-coded pointer copies for downstream CDC logic, plus full/empty/count status to the consumer side.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DEPTH, 16, FIFO entries; power of 2, ≥4. AW = $clog2(DEPTH).
- DW, 8, data width per requester.
- BURST, 4, maximum words accepted per grant (1..DEPTH).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester data valid.
- req_data  in  NREQ*DW  requester i data at bits [i*DW +: DW].
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- grant_id  out  $clog2(NREQ)  index of current/last granted requester.
- busy  out  1  high while in GRANT state.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  AW  RAM write address.
- ram_wdata  out  DW  RAM write data.
- rd_en  in  1  consumer pop request.
- ram_raddr  out  AW  RAM read address (= rd_ptr low bits).
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- count  out  AW+1  occupancy, 0..DEPTH.
- wr_ptr_gray  out  AW+1  Gray-coded write pointer, registered.
- rd_ptr_gray  out  AW+1  Gray-coded read pointer, registered.

Behaviour:
- Reset (rst=0 at clk edge):
  - State ARB; wr_ptr and rd_ptr (AW+1-bit binary) = 0; both Gray pointers = 0.
  - grant_id = 0, last-grant = NREQ-1 (requester 0 has first priority), beat counter = 0.
  - Outputs: req_ready = 0, busy = 0, ram_we = 0, empty = 1, full = 0, count = 0.
  - Reset mid-burst aborts the burst immediately; any word in flight that cycle is not written.
- FSM states:
  - ARB: scan req_valid starting at (last_grant+1) mod NREQ, wrapping. On first hit, register grant_id, set last_grant, go to GRANT. No hit: stay in ARB. One-cycle arbitration bubble.
  - GRANT: req_ready[grant_id] = !full; all other req_ready bits = 0.
    - Transfer occurs when req_valid[grant_id] && req_ready[grant_id]. Combinationally: ram_we = 1, ram_waddr = wr_ptr[AW-1:0], ram_wdata = selected req_data. Registered: wr_ptr +1, beat counter +1.
    - Exit to ARB, clearing the beat counter, on either condition: the transfer completes beat BURST, or req_valid[grant_id] = 0 in any GRANT cycle.
    - full alone does not end the grant; the requester stalls holding the grant.
- Read side:
  - Pop occurs when rd_en && !empty: rd_ptr +1 next edge. rd_en while empty is ignored; no pointer change.
- Status, derived from registered pointers:
  - empty = (wr_ptr == rd_ptr).
  - full = (MSBs differ && low AW bits equal).
  - count = wr_ptr - rd_ptr, modulo 2^(AW+1).
- Simultaneous push and pop: both take effect; count unchanged.
  - When full, a write is refused even if a pop occurs in the same cycle; it is accepted the following cycle.
  - When empty, a pop is refused even if a push occurs in the same cycle.
- Pointer wrap:
  - Binary pointers wrap from 2^(AW+1)-1 to 0 naturally.
  - Gray = bin ^ (bin >> 1), registered in the same cycle as the binary update, so Gray pointers change exactly one bit per increment, including at wrap.

Optional Feature:
- Macro FIFO_ARB_ERR_EN.
- Defined:
  - Adds output port err_underflow (1 bit), reset 0.
  - Set the cycle after rd_en=1 while empty=1; sticky until reset.
  - Adds output err_protocol (1 bit), sticky, set when req_valid[i] drops while req_ready[i]=0 and i==grant_id in GRANT. This flags a requester withdrawing a stalled word.
- Not defined: neither port exists; no extra logic.

Test Plan:
- Reset: hold rst=0 for 3 clocks with all req_valid=1 -> req_ready=0, empty=1, count=0, both Gray pointers 0, ram_we never 1.
- Round-robin: NREQ=4, BURST=4, all valid continuously with no reads -> grant order 0,1,2,3,0. Each grant writes 4 words at consecutive addresses. One idle cycle (ARB) between grants. full=1 after 16 words with count=16; req_ready=0 thereafter.
- Early release: only requester 2 valid, drops after 2 words -> exactly 2 writes at ram_waddr 0,1; back in ARB; next grant scan starts at requester 3.
- Full with simultaneous pop: fill to 16, then hold valid and rd_en together -> first cycle pop only (count 15); next cycle push+pop (count stays 15).
- Wrap: 40 pushes and 40 pops interleaved -> pointers pass 31→0. wr_ptr_gray sequence changes one bit per step, including 10000 (bin 31) → 00000. empty=1 at end.
- With FIFO_ARB_ERR_EN: rd_en=1 while empty -> err_underflow=1 next cycle and stays 1; rd_ptr unchanged.
